// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: bus widths, FSM state
// encodings and the handshake level constants used by div_iter.
package div_iter_pkg;

    // Machine word and double-word widths used across the datapath
    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 2 * RegBus;

    // Divider control states
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    // Levels of ready_o
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // Levels of start_i
    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step of the divider. The incoming partial
// remainder already has the next dividend bit shifted into its LSB; the
// divisor is trial-subtracted and the result kept only if it did not borrow.
module div_step
    import div_iter_pkg::*;
#(
    parameter int DATA_W = RegBus
) (
    input  logic [DATA_W+1:0] partial_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W:0]   partial_o,
    output logic              quot_bit_o
);

    logic [DATA_W+1:0] diff;

    // Trial subtraction; the top bit of the difference is the borrow
    always_comb begin
        diff       = partial_i - {2'b00, divisor_i};
        quot_bit_o = ~diff[DATA_W+1];
        if (quot_bit_o) begin
            partial_o = diff[DATA_W:0];
        end else begin
            partial_o = partial_i[DATA_W:0];
        end
    end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle signed/unsigned divider for the EX stage. Operands are latched
// as magnitudes when a divide starts, 32 restoring steps produce quotient and
// remainder, and the signs are fixed up on the way into the result state.
// The result is presented as {remainder, quotient} while start_i stays high.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    div_state_t state;
    div_state_t state_next;

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] dividend_r;
    logic [DATA_W-1:0] divisor_r;
    logic [DATA_W-1:0] quot_r;
    logic [DATA_W:0]   rem_r;
    logic              quot_neg;
    logic              rem_neg;

    logic latch_en;
    logic zero_en;
    logic step_en;
    logic finish_en;
    logic deliver;

    logic              op1_neg;
    logic              op2_neg;
    logic [DATA_W-1:0] op1_mag;
    logic [DATA_W-1:0] op2_mag;
    logic              last_step;

    logic [DATA_W+1:0] partial_in;
    logic [DATA_W:0]   step_rem;
    logic              step_q;
    logic [DATA_W-1:0] quot_final;
    logic [DATA_W-1:0] quot_fixed;
    logic [DATA_W-1:0] rem_fixed;

    // Operand magnitudes and sign flags as they would be latched this cycle
    always_comb begin
        op1_neg = signed_div_i & opdata1_i[DATA_W-1];
        op2_neg = signed_div_i & opdata2_i[DATA_W-1];
        op1_mag = op1_neg ? -opdata1_i : opdata1_i;
        op2_mag = op2_neg ? -opdata2_i : opdata2_i;
    end

    // Next dividend bit shifted into the partial remainder for this step
    always_comb begin
        partial_in = {rem_r, dividend_r[DATA_W-1]};
        last_step  = (cnt == CNT_W'(DATA_W - 1));
    end

    div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .partial_i  (partial_in),
        .divisor_i  (divisor_r),
        .partial_o  (step_rem),
        .quot_bit_o (step_q)
    );

    // Final step result with the recorded signs applied
    always_comb begin
        quot_final = {quot_r[DATA_W-2:0], step_q};
        quot_fixed = quot_neg ? -quot_final : quot_final;
        rem_fixed  = rem_neg ? -step_rem[DATA_W-1:0] : step_rem[DATA_W-1:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DivFree;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath enables; a cancel overrides everything else
    always_comb begin
        state_next = state;
        latch_en   = 1'b0;
        zero_en    = 1'b0;
        step_en    = 1'b0;
        finish_en  = 1'b0;
        deliver    = 1'b0;
        case (state)
            DivFree: begin
                if (start_i == DivStart && !annul_i) begin
                    latch_en = 1'b1;
                    if (opdata2_i == '0) begin
                        state_next = DivByZero;
                    end else begin
                        state_next = DivOn;
                    end
                end
            end
            DivByZero: begin
                zero_en    = 1'b1;
                state_next = DivEnd;
            end
            DivOn: begin
                step_en = 1'b1;
                if (last_step) begin
                    finish_en  = 1'b1;
                    state_next = DivEnd;
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_next = DivFree;
                end else begin
                    deliver = 1'b1;
                end
            end
            default: begin
                state_next = DivFree;
            end
        endcase
        if (annul_i) begin
            state_next = DivFree;
            latch_en   = 1'b0;
            zero_en    = 1'b0;
            step_en    = 1'b0;
            finish_en  = 1'b0;
            deliver    = 1'b0;
        end
    end

    // Operand latch, iteration registers and step counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            dividend_r <= '0;
            divisor_r  <= '0;
            quot_r     <= '0;
            rem_r      <= '0;
            quot_neg   <= 1'b0;
            rem_neg    <= 1'b0;
        end else begin
            if (latch_en) begin
                dividend_r <= op1_mag;
                divisor_r  <= op2_mag;
                quot_r     <= '0;
                rem_r      <= '0;
                quot_neg   <= op1_neg ^ op2_neg;
                rem_neg    <= op1_neg;
                cnt        <= '0;
            end else if (zero_en) begin
                quot_r <= '0;
                rem_r  <= '0;
            end else if (finish_en) begin
                quot_r <= quot_fixed;
                rem_r  <= {1'b0, rem_fixed};
                cnt    <= '0;
            end else if (step_en) begin
                dividend_r <= {dividend_r[DATA_W-2:0], 1'b0};
                quot_r     <= quot_final;
                rem_r      <= step_rem;
                cnt        <= cnt + CNT_W'(1);
            end
            if (annul_i) begin
                cnt <= '0;
            end
        end
    end

    // Registered result port: driven only while the consumer still holds start_i
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_o  <= DivResultNotReady;
            result_o <= '0;
        end else if (deliver) begin
            ready_o  <= DivResultReady;
            result_o <= {rem_r[DATA_W-1:0], quot_r};
        end else begin
            ready_o  <= DivResultNotReady;
            result_o <= '0;
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases followed by random
// divides, checked against a plain-arithmetic reference.
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int check_count;
    int pass_count;
    int fail_count;

    div_iter dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {remainder, quotient} from 64-bit integer arithmetic
    function automatic logic [63:0] refDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%016h expected 0x%016h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; the following posedge samples the request
    task automatic applyStimulus(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
    endtask

    // lat = number of edges after the sampling edge until ready_o is seen
    task automatic waitReady(output int lat, input bit scramble);
        lat = -1;
        do begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (scramble) begin
                signed_div_i = 1'($urandom_range(0, 1));
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
            end
        end while (ready_o !== 1'b1 && lat < 100);
    endtask

    task automatic finishDivide(input string tag, input logic [63:0] expected, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
            checkOutput({tag, "_hold_res"}, result_o, expected);
        end
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_drop_rdy"}, 64'(ready_o), 64'd0);
        checkOutput({tag, "_drop_res"}, result_o, 64'd0);
    endtask

    task automatic runDivide(input string tag, input bit sgn, input logic [31:0] a,
                             input logic [31:0] b, input logic [63:0] expected, input int hold);
        int lat;
        applyStimulus(sgn, a, b);
        waitReady(lat, 1'b1);
        checkOutput({tag, "_lat"}, 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
        checkOutput({tag, "_res"}, result_o, expected);
        finishDivide(tag, expected, hold);
    endtask

    initial begin
        int lat;
        bit sgn;
        logic [31:0] a;
        logic [31:0] b;

        check_count  = 0;
        pass_count   = 0;
        fail_count   = 0;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rdy", 64'(ready_o), 64'd0);
        checkOutput("reset_res", result_o, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("idle_rdy", 64'(ready_o), 64'd0);
        end

        runDivide("udiv_ffff_10", 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 64'h0000000F_0FFFFFFF, 1);
        runDivide("sdiv_m7_2", 1'b1, -32'd7, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1);
        runDivide("sdiv_7_m2", 1'b1, 32'd7, -32'd2, 64'h00000001_FFFFFFFD, 1);
        runDivide("div_by_zero", 1'b0, 32'h1234_5678, 32'd0, 64'd0, 1);
        runDivide("hold_end", 1'b1, 32'd1000, 32'd7, refDiv(1'b1, 32'd1000, 32'd7), 5);

        $display("[TB] annul during ON");
        applyStimulus(1'b0, 32'hCAFE_F00D, 32'd9);
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("annul_rdy", 64'(ready_o), 64'd0);
        checkOutput("annul_res", result_o, 64'd0);
        annul_i   = 1'b0;
        opdata1_i = 32'd5;
        opdata2_i = 32'd3;
        waitReady(lat, 1'b0);
        checkOutput("after_annul_lat", 64'(lat), 64'd33);
        checkOutput("after_annul_res", result_o, 64'h00000002_00000001);
        finishDivide("after_annul", 64'h00000002_00000001, 1);

        $display("[TB] reset during ON");
        applyStimulus(1'b0, 32'hDEAD_BEEF, 32'd3);
        for (int i = 0; i < 21; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_rdy", 64'(ready_o), 64'd0);
        checkOutput("midrst_res", result_o, 64'd0);
        rst = 1'b0;
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        waitReady(lat, 1'b0);
        checkOutput("min_by_m1_lat", 64'(lat), 64'd33);
        checkOutput("min_by_m1_res", result_o, 64'h00000000_80000000);
        finishDivide("min_by_m1", 64'h00000000_80000000, 1);

        $display("[TB] random divides");
        for (int i = 0; i < 10; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                3:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if (b == 32'd0 && $urandom_range(0, 1) == 1) b = 32'd1;
            runDivide("random", sgn, a, b, refDiv(sgn, a, b), 1);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 The block SHALL use these parameters: DATA_W, default 32, operand width; CNT_W, default 6, iteration counter width.
REQ-002 The block SHALL have input clk, 1 bit, rising-edge clock.
REQ-003 The block SHALL have input rst, 1 bit; reset rst, synchronous, active-high.
REQ-004 The block SHALL have input signed_div_i, 1 bit, 1 = DIV (two's complement), 0 = DIVU.
REQ-005 The block SHALL have input opdata1_i, 32 bits, dividend.
REQ-006 The block SHALL have input opdata2_i, 32 bits, divisor.
REQ-007 The block SHALL have input start_i, 1 bit, request from EX; held high until the result is consumed.
REQ-008 The block SHALL have input annul_i, 1 bit, cancel on flush/exception.
REQ-009 The block SHALL have output result_o, 64 bits, {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-010 The block SHALL have output ready_o, 1 bit, result valid.

Function
REQ-011 The block SHALL implement four states: FREE, BYZERO, ON, END.
REQ-012 FREE SHALL do the following: when start_i=1 and annul_i=0, latch signed_div_i and both operands; if divisor=0, go to BYZERO, else go to ON with counter=0.
REQ-013 In FREE with start_i=0 or annul_i=1, the block SHALL stay in FREE with ready_o=0 and result_o=0.
REQ-014 At latch, when signed_div_i=1, the block SHALL replace negative operands by their magnitudes, and SHALL record the quotient sign (XOR of the operand signs) and the remainder sign (dividend sign).
REQ-015 ON SHALL perform one restoring shift-subtract step per cycle for exactly 32 cycles (counter 0..31), then go to END.
REQ-016 Operand changes on the inputs during ON SHALL be ignored; only latched values are used.
REQ-017 BYZERO SHALL go to END next cycle with quotient=0 and remainder=0.
REQ-018 On entering END, the block SHALL apply sign correction: negate the quotient if the quotient sign is 1; negate the remainder if the remainder sign is 1 (signed only).
REQ-019 In END, the block SHALL assert ready_o=1 and hold result_o stable while start_i=1.
REQ-020 In END with start_i=0, the block SHALL go to FREE; ready_o=0 and result_o=0 the following cycle.
REQ-021 Latency: for start first sampled at edge N, ready_o SHALL be high after edge N+33 (normal) or after edge N+2 (divide-by-zero).
REQ-022 annul_i=1 in ON, BYZERO or END SHALL return the block to FREE at the next edge, with ready_o=0 and no result delivered.
REQ-023 annul_i SHALL have priority over all other transitions.
REQ-024 Arithmetic SHALL be modulo 2^32: 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0.
REQ-025 ready_o and result_o SHALL be registered outputs, with no combinational path from any input.
REQ-026 The block SHALL accept a new start only in FREE, so back-to-back divides incur one FREE cycle.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL force state=FREE, counter=0, ready_o=0, result_o=0, and clear all latched operands and sign flags.
REQ-028 Reset mid-ON or mid-END SHALL discard the operation.
REQ-029 After reset, the block SHALL act on start_i only once rst is low, from the first edge.

Structure
REQ-030 The state encodings DivFree/DivByZero/DivOn/DivEnd and DivResultReady/NotReady, DivStart/Stop SHALL reside in the shared defines file, next to RegBus and DoubleRegBus.
REQ-031 The single-step compare/subtract (34-bit partial remainder in, next partial remainder and quotient bit out) SHALL be one combinational sub-module, div_step.
REQ-032 Pipeline stall generation SHALL NOT be in this block; the EX stage derives stallreq from start_i && !ready_o.

Verification
REQ-033 Unsigned 0xFFFFFFFF / 0x00000010 -> ready_o at cycle 33, result_o = 0x0000000F_0FFFFFFF.
REQ-034 Signed -7 / 2 -> result_o = 0xFFFFFFFF_FFFFFFFD; signed 7 / -2 -> 0x00000001_FFFFFFFD.
REQ-035 Divisor 0 with dividend 0x12345678 -> ready_o at cycle 2, result_o = 0.
REQ-036 annul_i pulsed at ON cycle 10, start_i kept high -> FREE next cycle, ready_o stays 0; the next divide (5/3) returns 0x00000002_00000001 with full latency.
REQ-037 start_i held 5 extra cycles in END -> result_o stable and ready_o=1 throughout; start_i low -> ready_o=0 next cycle.
REQ-038 rst pulsed at ON cycle 20 -> all outputs 0 next cycle; a subsequent 0x80000000 / 0xFFFFFFFF signed returns 0x00000000_80000000.
